// File: rtl/fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_pkg : shared widths, tap shift table and sequencer state encoding     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fir_pkg;

  localparam int unsigned FIR_W     = 16;
  localparam int unsigned FIR_NTAPS = 5;

  // Logical right-shift applied to each delay-line entry, tap0 first.
  localparam int unsigned FIR_SHIFT [FIR_NTAPS] = '{5, 4, 3, 2, 1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

endpackage
`default_nettype wire

// File: rtl/fir_shared_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_shared_adder : single 16-bit adder time-shared by all taps            |
// | FIR_APPROX_ADD_EN selects the approximate low-byte carry scheme. Rev 1.0  |
// +--------------------------------------------------------------------------+
module fir_shared_adder
  import fir_pkg::*;
(
  input  logic [FIR_W-1:0] a,
  input  logic [FIR_W-1:0] b,
  output logic [FIR_W-1:0] sum
);

`ifdef FIR_APPROX_ADD_EN
  logic [7:0] w_carry_lo;
  logic       w_carry_hi;

  // Low byte: each carry comes only from the bit pair directly below it.
  assign w_carry_lo = {a[6:0] & b[6:0], 1'b0};
  assign w_carry_hi = a[7] & b[7];

  assign sum[7:0]  = a[7:0] ^ b[7:0] ^ w_carry_lo;
  assign sum[15:8] = a[15:8] + b[15:8] + {7'd0, w_carry_hi};
`else
  assign sum = a + b;
`endif

endmodule
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_tap_sequencer : 5-tap shift-coefficient FIR, one tap per cycle        |
// | Adder variant chosen by FIR_APPROX_ADD_EN in fir_shared_adder. Rev 1.0    |
// +--------------------------------------------------------------------------+
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS,
  parameter int W     = FIR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dataout,
  output logic         busy
);

  fir_state_e   state_q, state_d;
  logic [W-1:0] d_q [NTAPS];
  logic [W-1:0] d_d [NTAPS];
  logic [W-1:0] acc_q, acc_d;
  logic [2:0]   tap_q, tap_d;
  logic [W-1:0] dataout_q, dataout_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;

  logic [W-1:0] w_term [NTAPS];
  logic [W-1:0] w_tap_term;
  logic [W-1:0] w_sum;

  for (genvar k = 0; k < NTAPS; k++) begin : g_term
    assign w_term[k] = d_q[k] >> FIR_SHIFT[k];
  end

  always_comb begin
    w_tap_term = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (tap_q == 3'(k)) w_tap_term = w_term[k];
    end
  end

  fir_shared_adder u_adder (
    .a   (acc_q),
    .b   (w_tap_term),
    .sum (w_sum)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tap_d     = tap_q;
    dataout_d = dataout_q;
    for (int k = 0; k < NTAPS; k++) d_d[k] = d_q[k];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d[0] = x;
          for (int k = 1; k < NTAPS; k++) d_d[k] = d_q[k-1];
          acc_d   = '0;
          tap_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = w_sum;
        tap_d = tap_q + 3'd1;
        if (tap_q == 3'(NTAPS - 1)) begin
          dataout_d = w_sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered, decoded from the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tap_q       <= '0;
      dataout_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) d_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      dataout_q   <= dataout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      for (int k = 0; k < NTAPS; k++) d_q[k] <= d_d[k];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dataout   = dataout_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
